// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: prioritises exceptions, the timer interrupt and mret,
// latches mcause/mtval/mepc values and sequences the fetch redirect through a flush bubble.
module trap_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        instrValid_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] badAddr_i,
  input  logic        instrMisaligned_i,
  input  logic        illegalInstr_i,
  input  logic        ebreak_i,
  input  logic        ecall_i,
  input  logic        loadMisaligned_i,
  input  logic        storeMisaligned_i,
  input  logic        mret_i,
  input  logic        mtimeExc_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  output logic        jumpingToMtvec_o,
  output logic [31:0] excCause_o,
  output logic [31:0] trapInfo_o,
  output logic [31:0] trapPc_o,
  output logic        mretRestore_o,
  output logic        pcOverride_o,
  output logic [31:0] pcOverrideValue_o,
  output logic        stall_o
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {StIdle, StTrap, StRet, StFlush} state_e;

  state_e            state_q;
  logic [XLEN-1:0]   cause_q, tval_q, epc_q;
  logic              jump_q, restore_q;

  logic              exc_det;
  logic [XLEN-1:0]   cause_d, tval_d;
  logic              accept, take_exc, take_mret;

  // Mode bits of mtvec are dropped: only direct mode is supported.
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec_i[1:0];

  always_comb begin
    exc_det = 1'b1;
    cause_d = '0;
    tval_d  = '0;
    if (mtimeExc_i) begin
      cause_d = 32'h8000_0007;
    end else if (instrMisaligned_i) begin
      cause_d = 32'd0;
      tval_d  = badAddr_i;
    end else if (illegalInstr_i) begin
      cause_d = 32'd2;
      tval_d  = instr_i;
    end else if (ebreak_i) begin
      cause_d = 32'd3;
      tval_d  = pc_i;
    end else if (ecall_i) begin
      cause_d = 32'd11;
    end else if (loadMisaligned_i) begin
      cause_d = 32'd4;
      tval_d  = badAddr_i;
    end else if (storeMisaligned_i) begin
      cause_d = 32'd6;
      tval_d  = badAddr_i;
    end else begin
      exc_det = 1'b0;
    end
  end

  assign accept    = (state_q == StIdle) && instrValid_i && !rst;
  assign take_exc  = accept && exc_det;
  assign take_mret = accept && !exc_det && mret_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cause_q   <= '0;
      tval_q    <= '0;
      epc_q     <= '0;
      jump_q    <= 1'b0;
      restore_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (take_exc) begin
            state_q <= StTrap;
            cause_q <= cause_d;
            tval_q  <= tval_d;
            epc_q   <= pc_i;
            jump_q  <= 1'b1;
          end else if (take_mret) begin
            state_q   <= StRet;
            restore_q <= 1'b1;
          end
        end
        StTrap: begin
          state_q <= StFlush;
          jump_q  <= 1'b0;
        end
        StRet: begin
          state_q   <= StFlush;
          restore_q <= 1'b0;
        end
        StFlush: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign jumpingToMtvec_o  = jump_q;
  assign mretRestore_o     = restore_q;
  assign pcOverride_o      = jump_q | restore_q;
  assign pcOverrideValue_o = jump_q    ? {mtvec_i[31:2], 2'b00} :
                             restore_q ? mepc_i : '0;
  assign excCause_o        = cause_q;
  assign trapInfo_o        = tval_q;
  assign trapPc_o          = epc_q;
  // Detection stalls in the same cycle so the faulting instruction never retires.
  assign stall_o           = (state_q != StIdle) | take_exc | take_mret;

endmodule

// File: tb/tb_trap_sequencer.sv
// Self-checking bench for trap_sequencer: vector table plus a strobe scoreboard
// and hand-written sequences for held events and mid-trap reset.
module tb_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instrValid_i;
  logic [31:0] pc_i, instr_i, badAddr_i;
  logic        instrMisaligned_i, illegalInstr_i, ebreak_i, ecall_i;
  logic        loadMisaligned_i, storeMisaligned_i, mret_i, mtimeExc_i;
  logic [31:0] mtvec_i, mepc_i;
  logic        jumpingToMtvec_o, mretRestore_o, pcOverride_o, stall_o;
  logic [31:0] excCause_o, trapInfo_o, trapPc_o, pcOverrideValue_o;

  int checks = 0;
  int errors = 0;

  trap_sequencer dut (
    .clk               (clk),
    .rst               (rst),
    .instrValid_i      (instrValid_i),
    .pc_i              (pc_i),
    .instr_i           (instr_i),
    .badAddr_i         (badAddr_i),
    .instrMisaligned_i (instrMisaligned_i),
    .illegalInstr_i    (illegalInstr_i),
    .ebreak_i          (ebreak_i),
    .ecall_i           (ecall_i),
    .loadMisaligned_i  (loadMisaligned_i),
    .storeMisaligned_i (storeMisaligned_i),
    .mret_i            (mret_i),
    .mtimeExc_i        (mtimeExc_i),
    .mtvec_i           (mtvec_i),
    .mepc_i            (mepc_i),
    .jumpingToMtvec_o  (jumpingToMtvec_o),
    .excCause_o        (excCause_o),
    .trapInfo_o        (trapInfo_o),
    .trapPc_o          (trapPc_o),
    .mretRestore_o     (mretRestore_o),
    .pcOverride_o      (pcOverride_o),
    .pcOverrideValue_o (pcOverrideValue_o),
    .stall_o           (stall_o)
  );

  always #5 clk = ~clk;

  // exc bits: [6] mtime [5] imis [4] illegal [3] ebreak [2] ecall [1] lmis [0] smis
  typedef struct {
    logic        valid;
    logic [31:0] pc, instr, bad;
    logic [6:0]  exc;
    logic        mret;
    logic [31:0] mtvec, mepc;
    logic        ev, is_ret;
    logic [31:0] cause, tval, epc, ovr;
  } vec_t;

  typedef struct {
    logic        is_ret;
    logic [31:0] cause, tval, epc, ovr;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic valid, logic [31:0] pc, logic [31:0] instr,
                              logic [31:0] bad, logic [6:0] exc, logic mret,
                              logic [31:0] mtvec, logic [31:0] mepc, logic ev,
                              logic is_ret, logic [31:0] cause, logic [31:0] tval,
                              logic [31:0] epc, logic [31:0] ovr);
    vec_t v;
    v.valid = valid; v.pc = pc; v.instr = instr; v.bad = bad; v.exc = exc;
    v.mret = mret; v.mtvec = mtvec; v.mepc = mepc; v.ev = ev; v.is_ret = is_ret;
    v.cause = cause; v.tval = tval; v.epc = epc; v.ovr = ovr;
    return v;
  endfunction

  function automatic exp_t mk_exp(logic is_ret, logic [31:0] cause, logic [31:0] tval,
                                  logic [31:0] epc, logic [31:0] ovr);
    exp_t e;
    e.is_ret = is_ret; e.cause = cause; e.tval = tval; e.epc = epc; e.ovr = ovr;
    return e;
  endfunction

  // Scoreboard: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (jumpingToMtvec_o === 1'b1 || mretRestore_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe actual=jump%b/ret%b required=none",
                 jumpingToMtvec_o, mretRestore_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("strobe_jump", {31'b0, jumpingToMtvec_o}, {31'b0, !e.is_ret});
        chk("strobe_restore", {31'b0, mretRestore_o}, {31'b0, e.is_ret});
        chk("strobe_override", {31'b0, pcOverride_o}, 32'd1);
        chk("strobe_stall", {31'b0, stall_o}, 32'd1);
        chk("strobe_cause", excCause_o, e.cause);
        chk("strobe_tval", trapInfo_o, e.tval);
        chk("strobe_epc", trapPc_o, e.epc);
        chk("strobe_target", pcOverrideValue_o, e.ovr);
      end
    end
  end

  task automatic clear_events();
    instrValid_i = 1'b0;
    {mtimeExc_i, instrMisaligned_i, illegalInstr_i, ebreak_i, ecall_i,
     loadMisaligned_i, storeMisaligned_i} = 7'b0;
    mret_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    @(posedge clk); #1;
    instrValid_i = v.valid; pc_i = v.pc; instr_i = v.instr; badAddr_i = v.bad;
    {mtimeExc_i, instrMisaligned_i, illegalInstr_i, ebreak_i, ecall_i,
     loadMisaligned_i, storeMisaligned_i} = v.exc;
    mret_i = v.mret; mtvec_i = v.mtvec; mepc_i = v.mepc;
    @(negedge clk);
    chk("detect_stall", {31'b0, stall_o}, {31'b0, v.ev});
    if (v.ev) sb.push_back(mk_exp(v.is_ret, v.cause, v.tval, v.epc, v.ovr));
    @(posedge clk); #1;
    clear_events();
    @(negedge clk);
    chk("n1_stall", {31'b0, stall_o}, {31'b0, v.ev});
    @(posedge clk); #1;
    @(negedge clk);
    chk("flush_stall", {31'b0, stall_o}, {31'b0, v.ev});
    chk("flush_override", {31'b0, pcOverride_o}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("idle_stall", {31'b0, stall_o}, 32'd0);
    chk("sb_drained", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    int pulses;

    vecs.push_back(mk(1, 32'h100, 32'hFFFF_FFFF, 0, 7'b0010000, 0, 32'h200, 32'h84,
                      1, 0, 32'd2, 32'hFFFF_FFFF, 32'h100, 32'h200));
    vecs.push_back(mk(1, 32'h40, 0, 0, 7'b1000100, 0, 32'h200, 32'h84,
                      1, 0, 32'h8000_0007, 0, 32'h40, 32'h200));
    vecs.push_back(mk(1, 32'h300, 0, 32'h1003, 7'b0000010, 0, 32'h203, 32'h84,
                      1, 0, 32'd4, 32'h1003, 32'h300, 32'h200));
    vecs.push_back(mk(1, 32'h500, 0, 0, 7'b0000000, 1, 32'h203, 32'h84,
                      1, 1, 32'd4, 32'h1003, 32'h300, 32'h84));
    vecs.push_back(mk(1, 32'h10, 32'hDEAD_BEEF, 32'h2002, 7'b0111000, 0, 32'h1000, 32'h84,
                      1, 0, 32'd0, 32'h2002, 32'h10, 32'h1000));
    vecs.push_back(mk(1, 32'h7C, 0, 0, 7'b0001100, 0, 32'h1001, 32'h84,
                      1, 0, 32'd3, 32'h7C, 32'h7C, 32'h1000));
    vecs.push_back(mk(1, 32'h88, 0, 32'h55, 7'b0000110, 0, 32'h1002, 32'h84,
                      1, 0, 32'd11, 0, 32'h88, 32'h1000));
    vecs.push_back(mk(1, 32'h90, 0, 32'h4005, 7'b0000001, 0, 32'h200, 32'h84,
                      1, 0, 32'd6, 32'h4005, 32'h90, 32'h200));
    vecs.push_back(mk(1, 32'hA0, 0, 0, 7'b0000100, 1, 32'h200, 32'h84,
                      1, 0, 32'd11, 0, 32'hA0, 32'h200));
    vecs.push_back(mk(0, 32'hB0, 0, 0, 7'b0010000, 0, 32'h200, 32'h84,
                      0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 32'hC8, 0, 0, 7'b0000000, 1, 32'h200, 32'h1234,
                      1, 1, 32'd11, 0, 32'hA0, 32'h1234));
    vecs.push_back(mk(0, 32'hD0, 0, 0, 7'b0000000, 1, 32'h200, 32'h1234,
                      0, 0, 0, 0, 0, 0));

    rst = 1'b1;
    clear_events();
    pc_i = 0; instr_i = 0; badAddr_i = 0; mtvec_i = 0; mepc_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_stall", {31'b0, stall_o}, 32'd0);
    chk("reset_jump", {31'b0, jumpingToMtvec_o}, 32'd0);
    chk("reset_restore", {31'b0, mretRestore_o}, 32'd0);
    chk("reset_cause", excCause_o, 32'd0);
    chk("reset_tval", trapInfo_o, 32'd0);
    chk("reset_epc", trapPc_o, 32'd0);
    chk("reset_target", pcOverrideValue_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // ecall held for six cycles: taken at N and N+3 only.
    @(posedge clk); #1;
    instrValid_i = 1'b1; ecall_i = 1'b1; pc_i = 32'hC0; mtvec_i = 32'h200;
    sb.push_back(mk_exp(0, 32'd11, 0, 32'hC0, 32'h200));
    sb.push_back(mk_exp(0, 32'd11, 0, 32'hC0, 32'h200));
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (jumpingToMtvec_o === 1'b1) pulses++;
      chk("hold_jump", {31'b0, jumpingToMtvec_o}, {31'b0, (i == 1 || i == 4)});
      chk("hold_stall", {31'b0, stall_o}, 32'd1);
    end
    @(posedge clk); #1;
    clear_events();
    chk("hold_pulses", pulses, 32'd2);
    chk("hold_sb_drained", sb.size(), 32'd0);
    @(negedge clk);
    chk("hold_idle_stall", {31'b0, stall_o}, 32'd0);

    // Reset asserted while in TRAP aborts the sequence.
    @(posedge clk); #1;
    instrValid_i = 1'b1; illegalInstr_i = 1'b1; pc_i = 32'h600; instr_i = 32'h1234_5678;
    @(negedge clk);
    sb.push_back(mk_exp(0, 32'd2, 32'h1234_5678, 32'h600, 32'h200));
    @(posedge clk); #1;
    clear_events();
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_jump", {31'b0, jumpingToMtvec_o}, 32'd0);
    chk("rst_mid_restore", {31'b0, mretRestore_o}, 32'd0);
    chk("rst_mid_override", {31'b0, pcOverride_o}, 32'd0);
    chk("rst_mid_target", pcOverrideValue_o, 32'd0);
    chk("rst_mid_stall", {31'b0, stall_o}, 32'd0);
    chk("rst_mid_cause", excCause_o, 32'd0);
    chk("rst_mid_tval", trapInfo_o, 32'd0);
    chk("rst_mid_epc", trapPc_o, 32'd0);
    chk("rst_mid_sb", sb.size(), 32'd0);
    run_vec(mk(1, 32'h700, 0, 0, 7'b0000100, 0, 32'h200, 32'h84,
               1, 0, 32'd11, 0, 32'h700, 32'h200));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
